// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and constants for the bit-RAM word controller
//
// Purpose: controller state encoding, request op encodings and word-width helper.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int ADDR_W_DEF = 2;
  localparam int DEPTH      = 1 << ADDR_W_DEF;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // One RAM bit per address, so the word width equals the address space size.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_rd_align.sv
// rtl/ram_rd_align.sv - delays read-issue tags so they line up with RAM read data
//
// Purpose: RD_LAT-deep shift line of {valid, index}; RD_LAT=0 is a pass-through.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   issue_i     a read strobe is on the RAM this cycle
//   idx_i       address of that read
//   cap_en_o    ram_dout carries a requested bit this cycle
//   cap_idx_o   word bit index that ram_dout belongs to
module ram_rd_align #(
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] idx_i,
  output logic              cap_en_o,
  output logic [ADDR_W-1:0] cap_idx_o
);

  if (RD_LAT == 0) begin : g_pass
    assign cap_en_o  = issue_i;
    assign cap_idx_o = idx_i;
  end else begin : g_line
    logic              vld_q [RD_LAT];
    logic [ADDR_W-1:0] idx_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < RD_LAT; s++) begin
          vld_q[s] <= 1'b0;
          idx_q[s] <= '0;
        end
      end else begin
        vld_q[0] <= issue_i;
        idx_q[0] <= idx_i;
        for (int s = 1; s < RD_LAT; s++) begin
          vld_q[s] <= vld_q[s-1];
          idx_q[s] <= idx_q[s-1];
        end
      end
    end

    assign cap_en_o  = vld_q[RD_LAT-1];
    assign cap_idx_o = idx_q[RD_LAT-1];
  end

endmodule

// File: rtl/ram_word_ctrl.sv
// rtl/ram_word_ctrl.sv - serialises word read/write requests onto a bit-wide RAM
//
// Purpose: accepts a word request, performs one RAM bit access per address,
// returns the word (read data or write echo) on a response handshake.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_write, req_wdata             op (1 = write) and write word
//   rsp_valid/rsp_ready, rsp_rdata   response handshake and word
//   busy                             controller not idle
//   ram_a/ram_wr/ram_din/ram_rd      RAM address, write strobe, write bit, read strobe
//   ram_dout                         RAM read bit
module ram_word_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [2**ADDR_W-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2**ADDR_W-1:0] rsp_rdata,
  output logic                 busy,
  output logic [ADDR_W-1:0]    ram_a,
  output logic                 ram_wr,
  output logic                 ram_din,
  output logic                 ram_rd,
  input  logic                 ram_dout
);

  localparam int NBITS = depth_of(ADDR_W);
  // Counters are one bit wider than the address so "all done" is count == NBITS.
  localparam logic [ADDR_W:0] CNT_END = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W:0]   iss_cnt_q;   // address currently on the RAM (write or read issue)
  logic [ADDR_W:0]   cap_cnt_q;   // read bits captured so far
  logic [NBITS-1:0]  data_q;      // write word, or read word being assembled
  logic [ADDR_W-1:0] ram_a_q;
  logic              ram_wr_q;
  logic              ram_din_q;
  logic              ram_rd_q;
  logic              rsp_valid_q;

  logic              cap_en;
  logic [ADDR_W-1:0] cap_idx;
  logic [ADDR_W:0]   iss_cnt_d;
  logic [ADDR_W:0]   cap_cnt_d;
  logic [NBITS-1:0]  data_d;

  ram_rd_align #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_align (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_i   (ram_rd_q),
    .idx_i     (ram_a_q),
    .cap_en_o  (cap_en),
    .cap_idx_o (cap_idx)
  );

  assign iss_cnt_d = iss_cnt_q + 1'b1;
  assign cap_cnt_d = cap_cnt_q + 1'b1;

  always_comb begin
    data_d          = data_q;
    data_d[cap_idx] = ram_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      iss_cnt_q   <= '0;
      cap_cnt_q   <= '0;
      data_q      <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_din_q   <= 1'b0;
      ram_rd_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            iss_cnt_q <= '0;
            cap_cnt_q <= '0;
            ram_a_q   <= '0;
            case (req_write)
              OP_WRITE: begin
                state_q   <= ST_WRITE;
                data_q    <= req_wdata;
                ram_wr_q  <= 1'b1;
                ram_din_q <= req_wdata[0];
              end
              OP_READ: begin
                state_q  <= ST_READ;
                data_q   <= '0;
                ram_rd_q <= 1'b1;
              end
            endcase
          end
        end

        ST_WRITE: begin
          if (iss_cnt_d == CNT_END) begin
            state_q     <= ST_RESP;
            ram_wr_q    <= 1'b0;
            ram_din_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
          end else begin
            iss_cnt_q <= iss_cnt_d;
            ram_a_q   <= iss_cnt_d[ADDR_W-1:0];
            ram_din_q <= data_q[iss_cnt_d[ADDR_W-1:0]];
          end
        end

        ST_READ: begin
          // Issue side: ram_a holds the last address once all reads are out.
          if (ram_rd_q) begin
            if (iss_cnt_d == CNT_END) begin
              ram_rd_q <= 1'b0;
            end else begin
              iss_cnt_q <= iss_cnt_d;
              ram_a_q   <= iss_cnt_d[ADDR_W-1:0];
            end
          end
          // Capture side: runs RD_LAT cycles behind the issue side.
          if (cap_en) begin
            data_q    <= data_d;
            cap_cnt_q <= cap_cnt_d;
            if (cap_cnt_d == CNT_END) begin
              state_q     <= ST_RESP;
              ram_rd_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
            end
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            ram_a_q     <= '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = data_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_din   = ram_din_q;
  assign ram_rd    = ram_rd_q;

endmodule

// File: tb/tb_ram_word_ctrl.sv
// tb/tb_ram_word_ctrl.sv - self-checking bench for ram_word_ctrl against a bit-RAM model
module tb_ram_word_ctrl;

  localparam int ADDR_W = 2;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [DEPTH-1:0]  req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DEPTH-1:0]  rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic              ram_din;
  logic              ram_rd;
  logic              ram_dout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DEPTH-1:0] ref_word = '0;   // word held by the RAM, as the client sees it

  always #5 clk = ~clk;

  ram_word_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din),
    .ram_rd    (ram_rd),
    .ram_dout  (ram_dout)
  );

  // Bit RAM: write on edge, read data valid one cycle after the Rd edge.
  logic mem [DEPTH];
  logic dout_q = 1'b0;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 1'b0;
  always @(posedge clk) begin
    if (ram_wr) mem[ram_a] <= ram_din;
    if (ram_rd) dout_q <= mem[ram_a];
  end
  assign ram_dout = dout_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("wr_rd_excl", 32'(ram_wr & ram_rd), 32'd0);
    if (!busy) chk("idle_quiet", 32'({ram_a, ram_wr, ram_rd, rsp_valid}), 32'd0);
    else if (rsp_valid) chk("resp_quiet", 32'({ram_wr, ram_rd}), 32'd0);
  end

  // One full transaction from an idle negedge through the response handshake.
  task automatic do_txn(input logic wr, input logic [DEPTH-1:0] wd, input int stall, input logic hold);
    logic [DEPTH-1:0] exp_word;
    int lat;
    chk("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_wdata = wd;
    exp_word  = wr ? wd : ref_word;
    lat       = wr ? DEPTH + 1 : DEPTH + RD_LAT + 1;
    if (wr) ref_word = wd;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      req_valid = hold;
      req_write = 1'($urandom);
      req_wdata = DEPTH'($urandom);
      if (c == lat) begin
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_word));
      end else begin
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        chk("busy", 32'(busy), 32'd1);
        if (c <= DEPTH) begin
          chk("ram_a", 32'(ram_a), 32'(c - 1));
          chk("ram_wr", 32'(ram_wr), 32'(wr));
          chk("ram_rd", 32'(ram_rd), 32'(!wr));
          if (wr) chk("ram_din", 32'(ram_din), 32'(wd[c-1]));
        end else begin
          chk("drain_strobes", 32'({ram_wr, ram_rd}), 32'd0);
        end
      end
    end
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", 32'(rsp_rdata), 32'(exp_word));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_ready", 32'(req_ready), 32'd1);
    chk("post_hs_busy", 32'(busy), 32'd0);
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic wr;
    logic hold;

    // Reset with a request offered: nothing may be accepted.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wdata = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ram", 32'({ram_a, ram_wr, ram_din, ram_rd}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    end
    rst_n     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Directed write, read-back, and a stalled response.
    do_txn(1'b1, 4'b1011, 0, 1'b0);
    do_txn(1'b0, 4'b0000, 0, 1'b0);
    do_txn(1'b0, 4'b0000, 5, 1'b0);

    // Reset during the second read issue cycle.
    req_valid = 1'b1;
    req_write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rd_issue", 32'({ram_rd, ram_a}), 32'({1'b1, 2'd1}));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({ram_wr, ram_rd, ram_din}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(1'b1, 4'b0110, 0, 1'b0);
    do_txn(1'b0, 4'b0000, 0, 1'b0);

    // Back-to-back with req_valid held high.
    do_txn(1'b1, 4'b1111, 0, 1'b1);
    do_txn(1'b0, 4'b0000, 0, 1'b1);
    do_txn(1'b1, 4'b0000, 1, 1'b1);
    do_txn(1'b0, 4'b0000, 0, 1'b0);

    // Random traffic.
    for (int t = 0; t < 24; t++) begin
      wr   = 1'($urandom);
      hold = (t < 23) ? 1'($urandom) : 1'b0;
      do_txn(wr, DEPTH'($urandom), int'($urandom_range(0, 3)), hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
